// File: rtl/sccb_arbiter.sv
// sccb_arbiter: two-port register-write arbiter for one SCCB master.
// Port 0 has fixed priority; port 1 is guarded against starvation.
module sccb_arbiter #(
  parameter int I2C_ADDR_16    = 0,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int STARVE_LIMIT   = 4,
  localparam int AW = 8 + 8 * I2C_ADDR_16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_done,
  input  logic          p0_req,
  input  logic [AW-1:0] p0_addr,
  input  logic [7:0]    p0_data,
  output logic          p0_done,
  input  logic          p1_req,
  input  logic [AW-1:0] p1_addr,
  input  logic [7:0]    p1_data,
  output logic          p1_done,
  output logic          err,
  output logic          sccb_start,
  output logic [AW-1:0] sccb_addr,
  output logic [7:0]    sccb_data,
  input  logic          sccb_ready,
  output logic          busy
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    FINISH
  } state_t;

  localparam logic [15:0] TMO_LAST =
    16'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] SLIM =
    4'(STARVE_LIMIT);

  state_t        state;
  state_t        state_nx;
  logic          gnt_q;
  logic [AW-1:0] addr_q;
  logic [7:0]    data_q;
  logic [3:0]    starve_q;
  logic [15:0]   tcnt_q;
  logic          abort_q;
  logic          start_nx;

  logic p1_elig;
  logic any_req;
  logic pick_p1;
  logic grant;
  logic waiting;
  logic tmo_hit;

  assign p1_elig = p1_req & cfg_done;
  assign any_req = p0_req | p1_elig;
  assign pick_p1 = p1_elig &
    (~p0_req | (starve_q == SLIM));
  assign grant   = (state == IDLE) & any_req;
  assign waiting = (state == WAIT_BUSY) |
                   (state == WAIT_DONE);
  assign tmo_hit = (tcnt_q == TMO_LAST);

  assign sccb_addr = addr_q;
  assign sccb_data = data_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; a timeout overrides any wait
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (any_req) state_nx = ISSUE;
      ISSUE:
        if (sccb_ready) state_nx = WAIT_BUSY;
      WAIT_BUSY:
        if (tmo_hit)          state_nx = FINISH;
        else if (!sccb_ready) state_nx = WAIT_DONE;
      WAIT_DONE:
        if (tmo_hit || sccb_ready)
          state_nx = FINISH;
      FINISH:
        state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  // Output decode: done/err from FINISH, start request
  always_comb begin
    start_nx = 1'b0;
    p0_done  = 1'b0;
    p1_done  = 1'b0;
    err      = 1'b0;
    busy     = 1'b1;
    unique case (state)
      IDLE:  busy = 1'b0;
      ISSUE: start_nx = sccb_ready;
      FINISH: begin
        p0_done = ~gnt_q;
        p1_done = gnt_q;
        err     = abort_q;
      end
      default: ;
    endcase
  end

  // Registered one-cycle start pulse to the master
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sccb_start <= 1'b0;
    else        sccb_start <= start_nx;
  end

  // Latch the winner and its payload at grant time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else if (grant) begin
      unique case (1'b1)
        pick_p1: begin
          gnt_q  <= 1'b1;
          addr_q <= p1_addr;
          data_q <= p1_data;
        end
        !pick_p1: begin
          gnt_q  <= 1'b0;
          addr_q <= p0_addr;
          data_q <= p0_data;
        end
      endcase
    end
  end

  // Count port-0 wins while port 1 waits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else if (!p1_elig) begin
      starve_q <= '0;
    end else if (grant) begin
      if (pick_p1)
        starve_q <= '0;
      else if (starve_q != 4'd15)
        starve_q <= starve_q + 4'd1;
    end
  end

  // Transaction watchdog and abort flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_q  <= '0;
      abort_q <= 1'b0;
    end else begin
      if (start_nx)
        tcnt_q <= '0;
      else if (waiting && !tmo_hit)
        tcnt_q <= tcnt_q + 16'd1;
      if (grant)
        abort_q <= 1'b0;
      else if (waiting && tmo_hit)
        abort_q <= 1'b1;
    end
  end

endmodule

// File: doc/sccb_arbiter.md
SCCB_ARBITER -- requirements
Module: sccb_arbiter

Interface
REQ-001 Parameter I2C_ADDR_16, default 0, register-address width select: 0 gives 8 bits, 1 gives 16 bits (AW = 8+8*I2C_ADDR_16).
REQ-002 Parameter TIMEOUT_CYCLES, default 65535, maximum clk cycles from sccb_start to completion before abort; legal range 16..65535.
REQ-003 Parameter STARVE_LIMIT, default 4, maximum consecutive port-0 grants while port 1 is pending; legal range 1..15.
REQ-004 clk  in  1  system clock; all state changes on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 cfg_done  in  1  boot configuration finished; while low, port 1 is never granted.
REQ-007 p0_req  in  1  port 0 (boot config sequencer) write request, level.
REQ-008 p0_addr  in  AW  port 0 register address.
REQ-009 p0_data  in  8  port 0 register data.
REQ-010 p0_done  out  1  one-cycle pulse: port 0 transaction ended.
REQ-011 p1_req, p1_addr, p1_data, p1_done  in/in/in/out  1/AW/8/1  port 1 (runtime host write), same meaning as port 0.
REQ-012 err  out  1  one-cycle pulse, coincident with pX_done, when the transaction aborted on timeout.
REQ-013 sccb_start  out  1  one-cycle start pulse to the SCCB master.
REQ-014 sccb_addr  out  AW  address presented to the SCCB master.
REQ-015 sccb_data  out  8  data presented to the SCCB master.
REQ-016 sccb_ready  in  1  SCCB master idle, high when able to accept a start.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, FINISH; encoding is free.
REQ-019 Request rule: a requester holds pX_req high with stable addr/data until its pX_done; a req deasserted before grant is dropped silently.
REQ-020 IDLE to ISSUE when any eligible req is high; the grant and the addr/data are latched into internal registers in that transition cycle.
REQ-021 Arbitration: port 0 has fixed priority.
REQ-022 Starvation rule: when starve_cnt == STARVE_LIMIT and p1 is eligible, port 1 wins instead.
REQ-023 Eligibility: port 1 is eligible only when p1_req=1 and cfg_done=1.
REQ-024 starve_cnt increments on each port-0 grant while port 1 is eligible, clears on a port-1 grant or when port 1 is not eligible, and saturates at 15.
REQ-025 ISSUE: sccb_start=1 for exactly one cycle in the first cycle with sccb_ready=1, then go to WAIT_BUSY; the timeout counter clears when sccb_start fires.
REQ-026 WAIT_BUSY: go to WAIT_DONE when sccb_ready=0.
REQ-027 WAIT_DONE: go to FINISH when sccb_ready=1.
REQ-028 The timeout counter runs in WAIT_BUSY and WAIT_DONE; when it reaches TIMEOUT_CYCLES-1, go to FINISH with the abort flag set.
REQ-029 FINISH: pulse p0_done or p1_done (granted port only) for one cycle, plus err if aborted; return to IDLE the next cycle.
REQ-030 Latency: with sccb_ready already high, sccb_start occurs 2 cycles after the req is sampled in IDLE.
REQ-031 Back-to-back: a req still high in the cycle after pX_done is a new transaction.
REQ-032 sccb_addr and sccb_data come from the latched registers and hold steady from ISSUE through FINISH; requester inputs changing mid-transaction have no effect.
REQ-033 Simultaneous p0_req and p1_req in IDLE resolve per REQ-021..REQ-023 in the same cycle; the loser keeps waiting.
REQ-034 A cfg_done fall mid-transaction does not abort the granted port-1 transaction.

Reset
REQ-035 On rst_n low, immediately: state IDLE; sccb_start, p0_done, p1_done, err, busy = 0; latched grant, addr, data, starve_cnt and timeout counter = 0.
REQ-036 A reset mid-transaction gives no done pulse; after rst_n rises, the first sample in IDLE occurs on the next rising edge.

Verification
REQ-037 Single port-0 write 0x3008/0x82 (I2C_ADDR_16=1), model ready low for 300 cycles: expect one sccb_start with addr 0x3008, data 0x82, p0_done 1 cycle after ready returns high, err=0.
REQ-038 cfg_done=0, p1_req held 1000 cycles: expect no sccb_start; raise cfg_done: expect the port-1 transaction to start 2 cycles later.
REQ-039 Both ports continuously requesting, cfg_done=1, STARVE_LIMIT=4: expect grant order 0,0,0,0,1,0,0,0,0,1.
REQ-040 Model never drops ready after start, TIMEOUT_CYCLES=100: expect p0_done and err together exactly 100 cycles after sccb_start, then IDLE.
REQ-041 Assert rst_n low during WAIT_DONE: expect busy=0 and no done pulse; the next request is served normally.
REQ-042 Change p1_addr/p1_data during WAIT_DONE: expect sccb_addr/sccb_data unchanged until FINISH.
